// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer and the 8-bit ALU it drives.
// Holds the ALU opcode encodings, flag bit positions and the sequencer state type.
package alu_muldiv_seq_pkg;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   localparam logic [2:0] LAST_ITER_START = 3'd7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// Combinational 8-bit ALU: ADD and SUB with C/Z/N/V flags.
// On SUB, C=1 means no borrow (a >= b); V is signed overflow for both operations.
module alu
   import alu_muldiv_seq_pkg::*;
(
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic [3:0] i_op,
   output logic [7:0] o_out,
   output logic [3:0] o_flags
);

   logic [8:0] w_sum;
   logic [8:0] w_diff;
   logic [7:0] w_res;
   logic       w_carry;
   logic       w_ovf;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   // Select the operation result and derive carry/overflow for it
   always_comb begin
      w_res   = 8'h00;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (i_op)
         ALU_ADD: begin
            w_res   = w_sum[7:0];
            w_carry = w_sum[8];
            w_ovf   = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
         end
         ALU_SUB: begin
            w_res   = w_diff[7:0];
            w_carry = ~w_diff[8];
            w_ovf   = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
         end
         default: begin
            w_res   = 8'h00;
            w_carry = 1'b0;
            w_ovf   = 1'b0;
         end
      endcase
   end

   assign o_out = w_res;

   // Pack the flags into their fixed bit positions
   always_comb begin
      o_flags         = 4'h0;
      o_flags[FLAG_C] = w_carry;
      o_flags[FLAG_Z] = (w_res == 8'h00);
      o_flags[FLAG_N] = w_res[7];
      o_flags[FLAG_V] = w_ovf;
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 8x8 unsigned multiply (shift-add) and 8/8 unsigned divide (restoring)
// that performs every add and subtract through an external combinational ALU.
// r_acc holds the running high half (multiply) or partial remainder (divide);
// r_q holds the multiplier bits being consumed (multiply) or the quotient (divide).
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cmd,
   input  logic [7:0] opa,
   input  logic [7:0] opb,
   output logic       busy,
   output logic       done,
   output logic [7:0] res_hi,
   output logic [7:0] res_lo,
   output logic       div0,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [7:0] alu_out,
   input  logic [3:0] alu_flags
);

   state_t     r_state;
   logic [2:0] r_cnt;
   logic       r_cmd;
   logic [7:0] r_opnd;
   logic [7:0] r_acc;
   logic [7:0] r_q;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_resHi;
   logic [7:0] r_resLo;
   logic       r_div0;

   logic [7:0] w_shift;
   logic [7:0] w_aluA;
   logic [7:0] w_aluB;
   logic [3:0] w_aluOp;
   logic       w_carry;
   logic       w_take;
   logic       w_mulC;
   logic [7:0] w_mulS;
   logic [7:0] w_nextAcc;
   logic [7:0] w_nextQ;
   logic       w_unused_flags;

   assign w_shift        = {r_acc[6:0], r_q[7]};
   assign w_carry        = alu_flags[FLAG_C];
   assign w_unused_flags = ^alu_flags[3:1];

   // Drive the ALU from internal registers; park it on 0 + 0 when not running
   always_comb begin
      w_aluA  = 8'h00;
      w_aluB  = 8'h00;
      w_aluOp = ALU_ADD;
      if (r_state == RUN) begin
         w_aluB = r_opnd;
         if (r_cmd) begin
            w_aluA  = w_shift;
            w_aluOp = ALU_SUB;
         end else begin
            w_aluA  = r_acc;
         end
      end
   end

   assign alu_a  = w_aluA;
   assign alu_b  = w_aluB;
   assign alu_op = w_aluOp;

   // One iteration step: conditional add and shift for multiply, trial subtract for divide.
   // r_acc[7] marks a 9-bit shifted remainder, which always exceeds the divisor.
   always_comb begin
      w_take    = r_acc[7] | w_carry;
      w_mulC    = r_q[0] & w_carry;
      w_mulS    = r_q[0] ? alu_out : r_acc;
      w_nextAcc = {w_mulC, w_mulS[7:1]};
      w_nextQ   = {w_mulS[0], r_q[7:1]};
      if (r_cmd) begin
         w_nextAcc = w_take ? alu_out : w_shift;
         w_nextQ   = {r_q[6:0], w_take};
      end
   end

   // Sequencer FSM: accept in IDLE, iterate eight times in RUN, then publish results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
         r_cmd   <= 1'b0;
         r_opnd  <= 8'h00;
         r_acc   <= 8'h00;
         r_q     <= 8'h00;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_resHi <= 8'h00;
         r_resLo <= 8'h00;
         r_div0  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (cmd && (opb == 8'h00)) begin
                     r_done  <= 1'b1;
                     r_div0  <= 1'b1;
                     r_resHi <= opa;
                     r_resLo <= 8'hFF;
                  end else begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                     r_cnt   <= LAST_ITER_START;
                     r_cmd   <= cmd;
                     r_div0  <= 1'b0;
                     r_opnd  <= cmd ? opb : opa;
                     r_acc   <= 8'h00;
                     r_q     <= cmd ? opa : opb;
                  end
               end
            end
            RUN: begin
               r_acc <= w_nextAcc;
               r_q   <= w_nextQ;
               if (r_cnt == 3'd0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_resHi <= w_nextAcc;
                  r_resLo <= w_nextQ;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign res_hi = r_resHi;
   assign res_lo = r_resLo;
   assign div0   = r_div0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq driving the real ALU.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_muldiv_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       cmd;
   logic [7:0] opa;
   logic [7:0] opb;
   logic       busy;
   logic       done;
   logic [7:0] res_hi;
   logic [7:0] res_lo;
   logic       div0;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_out;
   logic [3:0] alu_flags;

   int checks   = 0;
   int failures = 0;

   alu_muldiv_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .cmd      (cmd),
      .opa      (opa),
      .opb      (opb),
      .busy     (busy),
      .done     (done),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .div0     (div0),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_out  (alu_out),
      .alu_flags(alu_flags)
   );

   alu u_alu (
      .i_a    (alu_a),
      .i_b    (alu_b),
      .i_op   (alu_op),
      .o_out  (alu_out),
      .o_flags(alu_flags)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   // Compare one observed value against its expected value and count it
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request for a single rising edge; call just after a falling edge
   task automatic applyStimulus(input logic c, input logic [7:0] a, input logic [7:0] b);
      cmd   = c;
      opa   = a;
      opb   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Walk the remaining busy cycles, then check the done cycle and results
   task automatic waitResult(input string tag, input int busyCycles, input logic [15:0] expRes,
                             input logic expDiv0);
      for (int i = 0; i < busyCycles; i++) begin
         @(negedge clk);
         checkOutput({tag, "_busy"}, {14'b0, busy, done}, 16'b10);
      end
      @(negedge clk);
      checkOutput({tag, "_done"}, {14'b0, busy, done}, 16'b01);
      checkOutput({tag, "_res"}, {res_hi, res_lo}, expRes);
      checkOutput({tag, "_div0"}, {15'b0, div0}, {15'b0, expDiv0});
   endtask

   // Check the cycle after a done pulse: pulse gone, results held
   task automatic checkAfter(input string tag, input logic [15:0] expRes);
      @(negedge clk);
      checkOutput({tag, "_after"}, {14'b0, busy, done}, 16'b00);
      checkOutput({tag, "_hold"}, {res_hi, res_lo}, expRes);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      cmd   = 1'b0;
      opa   = 8'h00;
      opb   = 8'h00;

      // Reset state
      #12;
      checkOutput("rst_ctrl", {13'b0, busy, done, div0}, 16'h0000);
      checkOutput("rst_res", {res_hi, res_lo}, 16'h0000);
      checkOutput("rst_alu", {alu_a, alu_b}, 16'h0000);
      checkOutput("rst_op", {12'b0, alu_op}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 13 x 11 = 143, also look at the first ALU drive
      applyStimulus(1'b0, 8'h0D, 8'h0B);
      @(negedge clk);
      checkOutput("mul13_busy1", {14'b0, busy, done}, 16'b10);
      checkOutput("mul13_alu", {alu_a, alu_b}, 16'h000D);
      checkOutput("mul13_op", {12'b0, alu_op}, 16'h0000);
      waitResult("mul13", 7, 16'h008F, 1'b0);
      checkAfter("mul13", 16'h008F);

      // 255 x 255 = 65025 exercises carry into the high byte
      @(negedge clk);
      applyStimulus(1'b0, 8'hFF, 8'hFF);
      waitResult("mul255", 8, 16'hFE01, 1'b0);

      // 0 x A5 = 0
      @(negedge clk);
      applyStimulus(1'b0, 8'h00, 8'hA5);
      waitResult("mul0", 8, 16'h0000, 1'b0);

      // 200 / 7 = 28 rem 4, also look at the first ALU drive
      @(negedge clk);
      applyStimulus(1'b1, 8'hC8, 8'h07);
      @(negedge clk);
      checkOutput("div200_alu", {alu_a, alu_b}, 16'h0107);
      checkOutput("div200_op", {12'b0, alu_op}, 16'h0001);
      waitResult("div200", 7, 16'h041C, 1'b0);

      // FF / 1 = FF rem 0
      @(negedge clk);
      applyStimulus(1'b1, 8'hFF, 8'h01);
      waitResult("divFF", 8, 16'h00FF, 1'b0);

      // 5 / 9 = 0 rem 5
      @(negedge clk);
      applyStimulus(1'b1, 8'h05, 8'h09);
      waitResult("div5", 8, 16'h0500, 1'b0);

      // 5A / 0: immediate done with div0, never busy
      @(negedge clk);
      applyStimulus(1'b1, 8'h5A, 8'h00);
      waitResult("div0", 0, 16'h5AFF, 1'b1);
      checkAfter("div0", 16'h5AFF);
      checkOutput("div0_held", {15'b0, div0}, 16'h0001);

      // Next valid op clears div0: 3 x 5 = 15
      applyStimulus(1'b0, 8'h03, 8'h05);
      waitResult("mul3", 8, 16'h000F, 1'b0);

      // Start during busy is ignored; previous result held while busy
      @(negedge clk);
      applyStimulus(1'b0, 8'h0D, 8'h0B);
      @(negedge clk);
      checkOutput("ign_hold", {res_hi, res_lo}, 16'h000F);
      @(negedge clk);
      @(negedge clk);
      applyStimulus(1'b1, 8'h63, 8'h03);
      waitResult("ign", 5, 16'h008F, 1'b0);

      // Back-to-back: start held into the done cycle
      @(negedge clk);
      applyStimulus(1'b1, 8'hC8, 8'h07);
      waitResult("b2b1", 8, 16'h041C, 1'b0);
      applyStimulus(1'b0, 8'hFF, 8'hFF);
      waitResult("b2b2", 8, 16'hFE01, 1'b0);
      checkAfter("b2b2", 16'hFE01);

      // Reset in the middle of a multiply
      applyStimulus(1'b0, 8'h14, 8'h14);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mrst_ctrl", {13'b0, busy, done, div0}, 16'h0000);
      checkOutput("mrst_res", {res_hi, res_lo}, 16'h0000);
      checkOutput("mrst_alu", {alu_a, alu_b}, 16'h0000);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("mrst_nodone", {14'b0, busy, done}, 16'b00);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checkOutput("mrst_quiet", {14'b0, busy, done}, 16'b00);
      end

      // New op after reset: 6 x 7 = 42
      applyStimulus(1'b0, 8'h06, 8'h07);
      waitResult("mul6", 8, 16'h002A, 1'b0);
      checkAfter("mul6", 16'h002A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
